muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU and owner of the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_sequencer_if.sv | 16 +
 rtl/muldiv_step.sv | 25 ++
 rtl/muldiv_sequencer.sv | 121 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared funct codes, FSM encoding and sizing for the HI/LO multiply/divide sequencer
package muldiv_pkg;
  localparam int DATA_W = 32;
  localparam int BPC_DEFAULT = 1;
  localparam int N = DATA_W / BPC_DEFAULT;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  function automatic logic is_hilo(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: execute-stage instruction/operand bus and HI/LO result bus
interface muldiv_sequencer_if;
  logic start;
  logic kill;
  logic [muldiv_pkg::DATA_W-1:0] ins;
  logic [muldiv_pkg::DATA_W-1:0] op1;
  logic [muldiv_pkg::DATA_W-1:0] op2;
  logic busy;
  logic done;
  logic stall;
  logic [muldiv_pkg::DATA_W-1:0] hi;
  logic [muldiv_pkg::DATA_W-1:0] lo;
  logic [muldiv_pkg::DATA_W-1:0] rd_data;
  modport master (output start, kill, ins, op1, op2, input busy, done, stall, hi, lo, rd_data);
  modport slave (input start, kill, ins, op1, op2, output busy, done, stall, hi, lo, rd_data);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on magnitudes
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              mul_i,
  input  logic [DATA_W-1:0] part_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] opd_i,
  output logic [DATA_W-1:0] part_o,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] sh;
  logic [DATA_W-1:0] diff;
  logic ge;
  // multiply consumes multiplier bits LSB-first; divide shifts dividend bits in MSB-first
  always_comb begin
    sum = {1'b0, part_i} + (q_i[0] ? {1'b0, opd_i} : '0);
    sh = {part_i, q_i[DATA_W-1]};
    ge = sh >= {1'b0, opd_i};
    diff = sh[DATA_W-1:0] - opd_i;
    part_o = mul_i ? sum[DATA_W:1] : (ge ? diff : sh[DATA_W-1:0]);
    q_o = mul_i ? {sum[0], q_i[DATA_W-1:1]} : {q_i[DATA_W-2:0], ge};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = BPC_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int NSTEP = DATA_W / BITS_PER_CYCLE;
  localparam int CW = $clog2(NSTEP);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, mul_q, mul_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, part_q, part_d, q_q, q_d, opd_q, opd_d;
  logic [DATA_W-1:0] part_c [BITS_PER_CYCLE+1];
  logic [DATA_W-1:0] q_c [BITS_PER_CYCLE+1];
  logic [DATA_W-1:0] m1, m2;
  logic [2*DATA_W-1:0] prod;
  logic [5:0] f;
  logic op_ok, hilo, md, sgn, mul, busy, unused_ins;
  assign f = bus.ins[5:0];
  assign op_ok = bus.ins[31:26] == 6'd0;
  assign unused_ins = ^bus.ins[25:6];
  assign hilo = op_ok & is_hilo(f);
  assign md = hilo & f[3];
  assign sgn = ~f[0];
  assign mul = ~f[1];
  assign m1 = sgn & bus.op1[DATA_W-1] ? -bus.op1 : bus.op1;
  assign m2 = sgn & bus.op2[DATA_W-1] ? -bus.op2 : bus.op2;
  assign busy = state_q != S_IDLE;
  assign prod = neg_q ? -{part_q, q_q} : {part_q, q_q};
  assign part_c[0] = part_q;
  assign q_c[0] = q_q;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    muldiv_step u_step (
      .mul_i (mul_q),
      .part_i(part_c[i]),
      .q_i   (q_c[i]),
      .opd_i (opd_q),
      .part_o(part_c[i+1]),
      .q_o   (q_c[i+1])
    );
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    part_d = part_q;
    q_d = q_q;
    opd_d = opd_q;
    mul_d = mul_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    if (bus.kill) state_d = S_IDLE;
    else if (state_q == S_IDLE) begin
      if (bus.start & md) begin
        state_d = S_RUN;
        cnt_d = '0;
        mul_d = mul;
        neg_d = sgn & (bus.op1[DATA_W-1] ^ bus.op2[DATA_W-1]);
        rneg_d = sgn & bus.op1[DATA_W-1];
        dz_d = ~mul & (bus.op2 == '0);
        part_d = '0;
        q_d = mul ? m2 : m1;
        opd_d = mul ? m1 : m2;
      end else if (bus.start & op_ok & (f == F_MTHI)) hi_d = bus.op1;
      else if (bus.start & op_ok & (f == F_MTLO)) lo_d = bus.op1;
    end else if (state_q == S_RUN) begin
      part_d = part_c[BITS_PER_CYCLE];
      q_d = q_c[BITS_PER_CYCLE];
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(NSTEP - 1) ? S_FIX : S_RUN;
    end else begin
      // a zero divisor leaves |op1| as remainder, so the sign fix restores op1 in hi
      state_d = S_IDLE;
      done_d = 1'b1;
      hi_d = mul_q ? prod[2*DATA_W-1:DATA_W] : (rneg_q ? -part_q : part_q);
      lo_d = mul_q ? prod[DATA_W-1:0] : (dz_q ? '1 : (neg_q ? -q_q : q_q));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      part_q <= '0;
      q_q <= '0;
      opd_q <= '0;
      mul_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      part_q <= part_d;
      q_q <= q_d;
      opd_q <= opd_d;
      mul_q <= mul_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
    end
  end
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.stall = bus.start & busy & hilo;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.rd_data = op_ok & (f == F_MFHI) ? hi_q : (op_ok & (f == F_MFLO) ? lo_q : '0);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of latency, results, stall, kill and reset
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  muldiv_sequencer_if bus ();
  muldiv_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.ins = {26'd0, fn};
    bus.op1 = a;
    bus.op2 = b;
  endtask
  task automatic idle_in();
    bus.start = 1'b0;
    bus.ins = 32'd0;
    bus.op1 = 32'd0;
    bus.op2 = 32'd0;
  endtask
  // called just after a rising edge; returns the index of the first cycle with done, 0 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    @(posedge clk);
    #1;
    issue(fn, a, b);
    @(posedge clk);
    #1;
    idle_in();
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd34);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    int k;
    int lat;
    logic got;
    bus.kill = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst_n = 1'b1;
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", F_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_wrap", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_zero", F_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_zero_neg", F_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("divu_big", F_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    // MFLO held from five cycles after MULT until released in the done cycle
    @(posedge clk);
    #1;
    issue(F_MULT, 32'd6, 32'd7);
    @(posedge clk);
    #1;
    idle_in();
    repeat (4) @(posedge clk);
    #1;
    issue(F_MFLO, 32'd0, 32'd0);
    k = 5;
    got = 1'b0;
    while (k < 120 && !got) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
      else begin
        chk("mflo_stall", 32'(bus.stall), 32'd1);
        k++;
        @(posedge clk);
        #1;
      end
    end
    chk("mflo_done_cycle", 32'(k), 32'd34);
    chk("mflo_release", 32'(bus.stall), 32'd0);
    chk("mflo_rd_data", bus.rd_data, 32'h0000002A);
    @(posedge clk);
    #1;
    issue(F_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("mfhi_rd_data", bus.rd_data, 32'd0);
    @(posedge clk);
    #1;
    issue(F_MTHI, 32'h12345678, 32'd0);
    @(negedge clk);
    chk("mthi_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    idle_in();
    @(negedge clk);
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_no_done", 32'(bus.done), 32'd0);
    chk("mthi_lo_kept", bus.lo, 32'h0000002A);
    // non-HI/LO funct while busy must not stall; a second DIV must stall and not queue
    @(posedge clk);
    #1;
    issue(F_MULTU, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    issue(6'b100000, 32'd1, 32'd1);
    @(negedge clk);
    chk("add_busy", 32'(bus.busy), 32'd1);
    chk("add_no_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    issue(F_DIV, 32'd100, 32'd7);
    @(negedge clk);
    chk("div_while_busy_stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    idle_in();
    wait_done(lat);
    chk("busy_op_latency", 32'(lat), 32'd32);
    chk("busy_op_hi", bus.hi, 32'd0);
    chk("busy_op_lo", bus.lo, 32'd6);
    @(posedge clk);
    @(negedge clk);
    chk("div_not_queued", 32'(bus.busy), 32'd0);
    // kill at RUN cycle 10
    @(posedge clk);
    #1;
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    idle_in();
    repeat (10) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(negedge clk);
    chk("kill_busy_before", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    chk("kill_busy_after", 32'(bus.busy), 32'd0);
    got = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    chk("kill_no_done", 32'(got), 32'd0);
    chk("kill_hi", bus.hi, 32'd0);
    chk("kill_lo", bus.lo, 32'd6);
    @(posedge clk);
    #1;
    issue(F_MULT, 32'd5, 32'd5);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    issue(F_MTLO, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    chk("kill_start_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    idle_in();
    @(negedge clk);
    chk("kill_mtlo_lo", bus.lo, 32'd6);
    // asynchronous reset in the middle of RUN
    @(posedge clk);
    #1;
    issue(F_MTHI, 32'hAAAA5555, 32'd0);
    @(posedge clk);
    #1;
    issue(F_MULT, 32'd6, 32'd7);
    @(posedge clk);
    #1;
    idle_in();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_hi", bus.hi, 32'hAAAA5555);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hi", bus.hi, 32'd0);
    chk("async_rst_lo", bus.lo, 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    chk("post_rst_lo", bus.lo, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
